// File: rtl/cpu_pkg.sv
// Shared core types: sequencer states, register-address width and the
// decoder control bundle with its NOP value used by stage flush muxes.
package cpu_pkg;

  localparam int CPU_REG_ADDR_W = 3;

  typedef enum logic {RUN, FLUSH} ctrl_state_t;

  typedef struct packed {
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic [3:0] alu_op;
  } decoder_signals;

  // Control word a squashed decode stage latches in place of the decoded one.
  localparam decoder_signals DECODER_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up on i_inc until all-ones; clear has priority over increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        r_count <= '0;
    else if (i_clr)                   r_count <= '0;
    else if (i_inc && r_count != '1)  r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables, NOP injection, branch redirect,
// load-use stall, memory freeze, perf counters and memory watchdog.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W   = CPU_REG_ADDR_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] dec_src_a,
  input  logic [REG_ADDR_W-1:0] dec_src_b,
  input  logic                  dec_use_a,
  input  logic                  dec_use_b,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_we,
  input  logic                  branch_taken,
  input  logic                  imem_valid,
  input  logic                  mem_busy,
  output logic                  fetch_en,
  output logic                  decode_en,
  output logic                  exec_en,
  output logic                  decode_flush,
  output logic                  exec_bubble,
  output logic                  pc_redirect,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output logic                  mem_timeout
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WDW = $clog2(MEM_TIMEOUT) + 1;

  ctrl_state_t    r_state;
  logic [FCW-1:0] r_flush_cnt;
  logic           r_mem_timeout;
  logic [WDW-1:0] w_wd_cnt;
  logic           w_load_use;
  logic           w_run;

  assign w_load_use = ex_is_load & ex_we &
                      ((dec_use_a & (dec_src_a == ex_dest)) |
                       (dec_use_b & (dec_src_b == ex_dest)));
  assign w_run      = !mem_busy && (r_state == RUN);

  // Stage controls: zero-latency decode of state and inputs in priority order.
  always_comb begin
    fetch_en     = 1'b1;
    decode_en    = 1'b1;
    exec_en      = 1'b1;
    decode_flush = 1'b0;
    exec_bubble  = 1'b0;
    pc_redirect  = 1'b0;
    if (rst) begin
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      exec_en      = 1'b0;
      decode_flush = 1'b1;
      exec_bubble  = 1'b1;
    end else if (mem_busy) begin
      fetch_en  = 1'b0;
      decode_en = 1'b0;
      exec_en   = 1'b0;
    end else if (r_state == FLUSH) begin
      decode_flush = 1'b1;
    end else if (branch_taken) begin
      pc_redirect  = 1'b1;
      decode_flush = 1'b1;
      exec_bubble  = 1'b1;
    end else if (w_load_use) begin
      fetch_en    = 1'b0;
      decode_en   = 1'b0;
      exec_bubble = 1'b1;
    end else if (!imem_valid) begin
      decode_flush = 1'b1;
    end
  end

  // Flush sequencer; everything holds while data memory is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else if (!mem_busy) begin
      case (r_state)
        RUN: begin
          if (branch_taken && FLUSH_CYCLES > 1) begin
            r_state     <= FLUSH;
            r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (r_flush_cnt == FCW'(1)) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Sticky watchdog flag once memory has been busy MEM_TIMEOUT cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                 r_mem_timeout <= 1'b0;
    else if (mem_busy && w_wd_cnt >= WDW'(MEM_TIMEOUT - 1))  r_mem_timeout <= 1'b1;
  end

  assign mem_timeout = r_mem_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk(clk), .i_rst(rst), .i_inc(w_run && !branch_taken && w_load_use),
    .i_clr(1'b0), .o_count(stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk(clk), .i_rst(rst), .i_inc(w_run && branch_taken),
    .i_clr(1'b0), .o_count(flush_count)
  );

  sat_counter #(.W(WDW)) u_wd_cnt (
    .i_clk(clk), .i_rst(rst), .i_inc(mem_busy),
    .i_clr(!mem_busy), .o_count(w_wd_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  localparam int RW = 3;
  localparam int CW = 16;

  // Control vector: {fetch_en, decode_en, exec_en, decode_flush, exec_bubble, pc_redirect}
  localparam logic [5:0] E_RUN = 6'b111000;
  localparam logic [5:0] E_LU  = 6'b001010;
  localparam logic [5:0] E_BR  = 6'b111111;
  localparam logic [5:0] E_FL  = 6'b111100;
  localparam logic [5:0] E_FRZ = 6'b000000;
  localparam logic [5:0] E_RST = 6'b000110;

  typedef struct packed {
    logic [RW-1:0] sa, sb, dst;
    logic          ua, ub, ld, we, br, iv, busy;
  } stim_t;

  logic          gclk = 1'b0;
  logic          rst  = 1'b0;
  logic [RW-1:0] dec_src_a, dec_src_b, ex_dest;
  logic          dec_use_a, dec_use_b, ex_is_load, ex_we, branch_taken, imem_valid, mem_busy;
  logic          fetch_en, decode_en, exec_en, decode_flush, exec_bubble, pc_redirect, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  int            n_chk = 0;
  int            n_err = 0;
  logic [5:0]    exp_q[$];

  always #5 gclk = ~gclk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(RW), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(CW)
  ) dut (
    .clk(gclk), .rst(rst),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest), .ex_we(ex_we),
    .branch_taken(branch_taken), .imem_valid(imem_valid), .mem_busy(mem_busy),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .decode_flush(decode_flush), .exec_bubble(exec_bubble), .pc_redirect(pc_redirect),
    .stall_count(stall_count), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    dec_src_a = s.sa;  dec_src_b = s.sb;  ex_dest = s.dst;
    dec_use_a = s.ua;  dec_use_b = s.ub;  ex_is_load = s.ld;
    ex_we = s.we;      branch_taken = s.br; imem_valid = s.iv; mem_busy = s.busy;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.iv = 1'b1;
    return s;
  endfunction

  // Load in execute writing dst; decode reads sa via port A when ua.
  function automatic stim_t lu_a(input logic [RW-1:0] d, input logic [RW-1:0] a, input logic ua);
    stim_t s = idle();
    s.ld = 1'b1; s.we = 1'b1; s.dst = d; s.sa = a; s.ua = ua;
    return s;
  endfunction

  task automatic pop_chk(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {26'd0, fetch_en, decode_en, exec_en, decode_flush, exec_bubble, pc_redirect}, {26'd0, e});
    end
  endtask

  // One cycle: drive at negedge, push expectation, compare before the rising edge.
  task automatic cyc(input stim_t s, input logic [5:0] e, input string tag);
    @(negedge gclk);
    apply(s);
    exp_q.push_back(e);
    #1;
    pop_chk(tag);
  endtask

  initial begin
    stim_t s;
    apply(idle());
    #2 rst = 1'b1;

    // Reset: stages disabled, decode/execute squashed.
    repeat (3) begin
      @(negedge gclk);
      exp_q.push_back(E_RST);
      #1;
      pop_chk("rst_ctl");
    end
    rst = 1'b0;
    cyc(idle(), E_RUN, "post_rst");
    chk("rst_stall", stall_count, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_wd",    mem_timeout, 0);

    // Load-use on A, then A unused, then on B, then non-writing load, then r0.
    cyc(lu_a(3'd3, 3'd3, 1'b1), E_LU, "lu_a");
    cyc(idle(), E_RUN, "lu_a_after");
    chk("stall_1", stall_count, 1);
    cyc(lu_a(3'd3, 3'd3, 1'b0), E_RUN, "lu_a_unused");
    s = lu_a(3'd5, 3'd1, 1'b0); s.ub = 1'b1; s.sb = 3'd5;
    cyc(s, E_LU, "lu_b");
    s = lu_a(3'd3, 3'd3, 1'b1); s.we = 1'b0;
    cyc(s, E_RUN, "lu_no_we");
    cyc(lu_a(3'd0, 3'd0, 1'b1), E_LU, "lu_r0");
    cyc(idle(), E_RUN, "lu_r0_after");
    chk("stall_3", stall_count, 3);

    // Taken branch: redirect cycle, one squash cycle (second branch ignored), clean.
    s = idle(); s.br = 1'b1;
    cyc(s, E_BR, "br_c0");
    cyc(s, E_FL, "br_c1_ignored");
    cyc(idle(), E_RUN, "br_c2");
    chk("flush_1", flush_count, 1);

    // Branch and load-use together: branch wins, no stall counted.
    s = lu_a(3'd2, 3'd2, 1'b1); s.br = 1'b1;
    cyc(s, E_BR, "br_lu_c0");
    cyc(lu_a(3'd2, 3'd2, 1'b1), E_FL, "br_lu_c1");
    cyc(idle(), E_RUN, "br_lu_c2");
    chk("br_lu_stall", stall_count, 3);
    chk("flush_2", flush_count, 2);

    // Short busy burst does not trip the watchdog.
    s = idle(); s.busy = 1'b1;
    repeat (3) cyc(s, E_FRZ, "frz3");
    cyc(idle(), E_RUN, "frz3_rel");
    chk("wd_3", mem_timeout, 0);

    // Four busy cycles trip it; flag sticks after release.
    repeat (4) cyc(s, E_FRZ, "frz4");
    chk("wd_4_pre", mem_timeout, 0);
    cyc(idle(), E_RUN, "frz4_rel");
    chk("wd_4_set", mem_timeout, 1);
    cyc(idle(), E_RUN, "frz4_idle");
    chk("wd_4_sticky", mem_timeout, 1);

    // Freeze in the middle of a flush; remaining squash cycle completes afterward.
    s = idle(); s.br = 1'b1;
    cyc(s, E_BR, "fl_frz_c0");
    s = idle(); s.busy = 1'b1;
    repeat (5) cyc(s, E_FRZ, "fl_frz_hold");
    cyc(idle(), E_FL, "fl_frz_c1");
    cyc(idle(), E_RUN, "fl_frz_c2");
    chk("flush_3", flush_count, 3);

    // Branch held through a freeze is taken on the first free cycle.
    s = idle(); s.br = 1'b1; s.busy = 1'b1;
    repeat (2) cyc(s, E_FRZ, "br_frz_hold");
    s.busy = 1'b0;
    cyc(s, E_BR, "br_frz_take");
    cyc(idle(), E_FL, "br_frz_c1");
    cyc(idle(), E_RUN, "br_frz_c2");
    chk("flush_4", flush_count, 4);

    // Fetch bubble, and load-use outranking a fetch bubble.
    s = idle(); s.iv = 1'b0;
    cyc(s, E_FL, "imem_bubble");
    s = lu_a(3'd6, 3'd6, 1'b1); s.iv = 1'b0;
    cyc(s, E_LU, "lu_over_bubble");
    cyc(idle(), E_RUN, "bubble_after");
    chk("stall_4", stall_count, 4);

    // Saturate the stall counter by holding a hazard.
    @(negedge gclk);
    apply(lu_a(3'd4, 3'd4, 1'b1));
    repeat (65540) @(posedge gclk);
    cyc(lu_a(3'd4, 3'd4, 1'b1), E_LU, "lu_sat");
    chk("stall_sat", stall_count, 32'h0000_FFFF);
    cyc(idle(), E_RUN, "sat_after");
    chk("stall_sat_hold", stall_count, 32'h0000_FFFF);

    // Asynchronous reset mid-flush: everything clears, back to RUN.
    s = idle(); s.br = 1'b1;
    cyc(s, E_BR, "rst_fl_c0");
    @(negedge gclk);
    apply(idle());
    #2 rst = 1'b1;
    exp_q.push_back(E_RST);
    #1;
    pop_chk("rst_mid_ctl");
    chk("rst_mid_stall", stall_count, 0);
    chk("rst_mid_flush", flush_count, 0);
    chk("rst_mid_wd",    mem_timeout, 0);
    #1 rst = 1'b0;
    cyc(idle(), E_RUN, "rst_mid_run");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
